// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: iterative EXP_W/MAN_W float add/sub, RNE, valid/ready.
// Define FPU_ADDSUB_SPECIALS_EN for IEEE inf/NaN operands and inf on overflow.
module fpu_addsub_pipe #(
  parameter  int EXP_W = 11,
  parameter  int MAN_W = 20,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clock_100k,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out
);

  localparam int DP = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int MW = MAN_W + 1;
  localparam int SW = $clog2(DP);
  localparam int LW = $clog2(DP + 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE
  } state_t;

  state_t state_q, state_d;
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic sub_q, sub_d;
  logic [W-1:0] res_q, res_d;
  logic [3:0] st_q, st_d;
  logic sgb_q, sgb_d, sgs_q, sgs_d;
  logic [EW-1:0] exb_q, exb_d, exs_q, exs_d;
  logic [MW-1:0] mnb_q, mnb_d, mns_q, mns_d;
  logic [DP-1:0] al_q, al_d;
  logic [DP:0] sum_q, sum_d;
  logic sg_q, sg_d;
  logic [DP-1:0] m_q, m_d;
  logic [EW-1:0] e_q, e_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_ready_q && in_valid) state_d = UNPACK;
      UNPACK:  state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    sub_d = sub_q;
    if (state_q == IDLE && in_ready_q && in_valid) begin
      a_d   = op_a;
      b_d   = op_b;
      sub_d = op_sub;
    end
  end

  logic sa, sb, a_big;
  logic [EXP_W-1:0] fea, feb;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] ma, mb;

  always_comb begin
    sa  = a_q[W-1];
    sb  = b_q[W-1] ^ sub_q;
    fea = a_q[W-2 -: EXP_W];
    feb = b_q[W-2 -: EXP_W];
    ea  = (fea == '0) ? EW'(1) : EW'(fea);
    eb  = (feb == '0) ? EW'(1) : EW'(feb);
    ma  = {|fea, a_q[MAN_W-1:0]};
    mb  = {|feb, b_q[MAN_W-1:0]};
    a_big = {ea, ma} >= {eb, mb};
    sgb_d = sgb_q;
    sgs_d = sgs_q;
    exb_d = exb_q;
    exs_d = exs_q;
    mnb_d = mnb_q;
    mns_d = mns_q;
    if (state_q == UNPACK) begin
      sgb_d = a_big ? sa : sb;
      sgs_d = a_big ? sb : sa;
      exb_d = a_big ? ea : eb;
      exs_d = a_big ? eb : ea;
      mnb_d = a_big ? ma : mb;
      mns_d = a_big ? mb : ma;
    end
  end

  logic [EW-1:0] dif;
  logic [DP-1:0] ext, shd, msk;

  always_comb begin
    dif  = exb_q - exs_q;
    ext  = {mns_q, 3'b000};
    shd  = ext >> dif[SW-1:0];
    msk  = ~({DP{1'b1}} << dif[SW-1:0]);
    al_d = al_q;
    if (state_q == ALIGN) begin
      if (dif >= EW'(DP - 1))
        al_d = {{(DP-1){1'b0}}, |mns_q};
      else
        al_d = {shd[DP-1:1], shd[0] | (|(ext & msk))};
    end
  end

  logic [DP:0] bext, sum;

  always_comb begin
    bext = {1'b0, mnb_q, 3'b000};
    sum  = (sgb_q == sgs_q) ? bext + {1'b0, al_q}
                            : bext - {1'b0, al_q};
    sum_d = sum_q;
    sg_d  = sg_q;
    if (state_q == ADD) begin
      sum_d = sum;
      // an exact zero is negative only when both addends were negative
      sg_d  = (sum == '0) ? (sgb_q & sgs_q) : sgb_q;
    end
  end

  logic [LW-1:0] lz;
  logic [EW-1:0] lim, sh;

  always_comb begin
    lz = LW'(DP);
    for (int i = 0; i < DP; i++)
      if (sum_q[i]) lz = LW'(DP - 1 - i);
    lim = exb_q - EW'(1);
    sh  = (EW'(lz) > lim) ? lim : EW'(lz);
    m_d = m_q;
    e_d = e_q;
    if (state_q == NORM) begin
      if (sum_q[DP]) begin
        m_d = {sum_q[DP:2], sum_q[1] | sum_q[0]};
        e_d = exb_q + EW'(1);
      end else begin
        m_d = sum_q[DP-1:0] << sh;
        e_d = exb_q - sh;
      end
    end
  end

`ifdef FPU_ADDSUB_SPECIALS_EN
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic spc_q, spc_d;
  logic [W-1:0] spr_q, spr_d;
  logic [3:0] sps_q, sps_d;
  logic ia, ib, na, nb;

  always_comb begin
    ia = (&fea) & ~(|a_q[MAN_W-1:0]);
    ib = (&feb) & ~(|b_q[MAN_W-1:0]);
    na = (&fea) & (|a_q[MAN_W-1:0]);
    nb = (&feb) & (|b_q[MAN_W-1:0]);
    spc_d = spc_q;
    spr_d = spr_q;
    sps_d = sps_q;
    if (state_q == UNPACK) begin
      spc_d = 1'b1;
      spr_d = QNAN;
      sps_d = 4'b0000;
      if (na || nb) begin
        sps_d = 4'b0000;
      end else if (ia && ib && (sa != sb)) begin
        sps_d = 4'b0001;
      end else if (ia) begin
        spr_d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        sps_d = 4'b1000;
      end else if (ib) begin
        spr_d = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        sps_d = 4'b1000;
      end else begin
        spc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_100k) begin
    if (reset) begin
      spc_q <= 1'b0;
      spr_q <= '0;
      sps_q <= '0;
    end else begin
      spc_q <= spc_d;
      spr_q <= spr_d;
      sps_q <= sps_d;
    end
  end
`endif

  logic g, r, s, inc, hid, inx, ovf, unf;
  logic [MW:0] mr;
  logic [EW-1:0] er;
  logic [MAN_W-1:0] fr;
  logic [EXP_W-1:0] ef;

  always_comb begin
    g   = m_q[2];
    r   = m_q[1];
    s   = m_q[0];
    inc = g & (r | s | m_q[3]);
    mr  = {1'b0, m_q[DP-1:3]} + {{MW{1'b0}}, inc};
    er  = e_q;
    fr  = mr[MAN_W-1:0];
    hid = mr[MAN_W];
    if (mr[MW]) begin
      er  = e_q + EW'(1);
      fr  = mr[MAN_W:1];
      hid = 1'b1;
    end
    ovf = hid && (er >= EMAX);
    inx = g | r | s | ovf;
    unf = ~hid & inx;
    ef  = hid ? er[EXP_W-1:0] : '0;
    res_d = res_q;
    st_d  = st_q;
    if (state_q == ROUND) begin
      res_d = {sg_q, ef, fr};
      if (ovf) begin
`ifdef FPU_ADDSUB_SPECIALS_EN
        res_d = {sg_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
        res_d = {sg_q, EXP_W'(EMAX - EW'(1)), {MAN_W{1'b1}}};
`endif
      end
      st_d = {~inx, ovf, unf, inx};
`ifdef FPU_ADDSUB_SPECIALS_EN
      if (spc_q) begin
        res_d = spr_q;
        st_d  = sps_q;
      end
`endif
    end
  end

  always_ff @(posedge clock_100k) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      res_q       <= '0;
      st_q        <= '0;
      sgb_q       <= 1'b0;
      sgs_q       <= 1'b0;
      exb_q       <= '0;
      exs_q       <= '0;
      mnb_q       <= '0;
      mns_q       <= '0;
      al_q        <= '0;
      sum_q       <= '0;
      sg_q        <= 1'b0;
      m_q         <= '0;
      e_q         <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      res_q       <= res_d;
      st_q        <= st_d;
      sgb_q       <= sgb_d;
      sgs_q       <= sgs_d;
      exb_q       <= exb_d;
      exs_q       <= exs_d;
      mnb_q       <= mnb_d;
      mns_q       <= mns_d;
      al_q        <= al_d;
      sum_q       <= sum_d;
      sg_q        <= sg_d;
      m_q         <= m_d;
      e_q         <= e_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign data_out   = res_q;
  assign status_out = st_q;

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// tb_fpu_addsub_pipe: directed vectors, queue scoreboard, handshake/reset.
// Build with FPU_ADDSUB_SPECIALS_EN to also cover inf/NaN expectations.
module tb_fpu_addsub_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  always #5 clk = ~clk;

  fpu_addsub_pipe dut (
    .clock_100k (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_sub     (op_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .status_out (status_out)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic [7:0]  id;
  } sb_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] d;
    logic [3:0]  s;
  } vec_t;

  sb_t  q[$];
  vec_t vt[$];
  sb_t  cur;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && !ov_prev) begin
        n_vec++;
        if (cyc - acc_cyc + 1 != 6) begin
          n_bad++;
          $display("FAIL latency: out_valid in cycle %0d after accept, want 6",
                   cyc - acc_cyc + 1);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_result: got %h/%b, want no output",
                   data_out, status_out);
        end else begin
          cur = q.pop_front();
          if (data_out !== cur.d || status_out !== cur.s) begin
            n_bad++;
            $display("FAIL vec%0d: got %h/%b, want %h/%b",
                     cur.id, data_out, status_out, cur.d, cur.s);
          end
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic chk(input string nm, input logic [35:0] act,
                     input logic [35:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] b,
                     input logic sub, input logic [31:0] d,
                     input logic [3:0] s);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.d = d; v.s = s;
    vt.push_back(v);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] d,
                       input logic [3:0] s, input logic [7:0] id,
                       input bit push);
    int n = 0;
    sb_t e;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL issue_timeout vec%0d: in_ready got 0, want 1", id);
      return;
    end
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
    if (push) begin
      e.d = d; e.s = s; e.id = id;
      q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results outstanding, want 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0;
    op_sub = 1'b0; out_ready = 1'b1;

    add(32'h3FF00000, 32'h3FF00000, 1'b0, 32'h40000000, 4'b1000);
    add(32'h40000000, 32'h3FF00000, 1'b1, 32'h3FF00000, 4'b1000);
    add(32'h3FF00000, 32'h3FF00000, 1'b1, 32'h00000000, 4'b1000);
    add(32'h3FF00000, 32'h3EA00000, 1'b0, 32'h3FF00000, 4'b0001);
    add(32'h3FF00001, 32'h3EA00000, 1'b0, 32'h3FF00002, 4'b0001);
    add(32'h3FF00000, 32'h3EA80000, 1'b0, 32'h3FF00001, 4'b0001);
    add(32'h3FFFFFFF, 32'h3EA00000, 1'b0, 32'h40000000, 4'b0001);
    add(32'h3FF00000, 32'h00000001, 1'b0, 32'h3FF00000, 4'b0001);
    add(32'h00100000, 32'h000FFFFF, 1'b1, 32'h00000001, 4'b1000);
    add(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b1000);
    add(32'h00200000, 32'h00000001, 1'b1, 32'h001FFFFF, 4'b1000);
    add(32'h3FF00001, 32'h3FF00000, 1'b1, 32'h3EB00000, 4'b1000);
    add(32'h3FF00000, 32'h40000000, 1'b1, 32'hBFF00000, 4'b1000);
    add(32'hBFF00000, 32'hBFF00000, 1'b0, 32'hC0000000, 4'b1000);
    add(32'h3FF00000, 32'hBFF00000, 1'b0, 32'h00000000, 4'b1000);
    add(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b1000);
`ifdef FPU_ADDSUB_SPECIALS_EN
    add(32'h7FEFFFFF, 32'h7FEFFFFF, 1'b0, 32'h7FF00000, 4'b0101);
    add(32'hFFEFFFFF, 32'hFFEFFFFF, 1'b0, 32'hFFF00000, 4'b0101);
    add(32'h7FF00000, 32'hFFF00000, 1'b0, 32'h7FF80000, 4'b0001);
    add(32'h7FF80001, 32'h3FF00000, 1'b0, 32'h7FF80000, 4'b0000);
    add(32'h7FF00000, 32'h3FF00000, 1'b0, 32'h7FF00000, 4'b1000);
    add(32'h3FF00000, 32'h7FF00000, 1'b1, 32'hFFF00000, 4'b1000);
`else
    add(32'h7FEFFFFF, 32'h7FEFFFFF, 1'b0, 32'h7FEFFFFF, 4'b0101);
    add(32'hFFEFFFFF, 32'hFFEFFFFF, 1'b0, 32'hFFEFFFFF, 4'b0101);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 36'(in_ready), 36'd0);
    chk("reset_out_valid", 36'(out_valid), 36'd0);
    chk("reset_result", {data_out, status_out}, 36'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("release_in_ready", 36'(in_ready), 36'd1);

    for (int i = 0; i < vt.size(); i++)
      issue(vt[i].a, vt[i].b, vt[i].sub, vt[i].d, vt[i].s, 8'(i), 1'b1);
    wait_drain();

    out_ready = 1'b0;
    issue(32'h3FF00000, 32'h3FF00000, 1'b0, 32'h40000000, 4'b1000,
          8'd100, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", 36'(out_valid), 36'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      op_a = 32'h12345678; op_b = 32'h3FF00000; op_sub = 1'b0;
      chk("hold_data", {data_out, status_out}, {32'h40000000, 4'b1000});
      chk("hold_in_ready", 36'(in_ready), 36'd0);
      chk("hold_out_valid", 36'(out_valid), 36'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);
    chk("post_hs_out_valid", 36'(out_valid), 36'd0);
    chk("post_hs_in_ready", 36'(in_ready), 36'd1);
    chk("post_hs_data_kept", {data_out, status_out},
        {32'h40000000, 4'b1000});

    issue(32'h3FF00000, 32'h40000000, 1'b0, 32'h0, 4'h0, 8'd200, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_align_result", {data_out, status_out}, 36'd0);
    chk("rst_align_out_valid", 36'(out_valid), 36'd0);
    chk("rst_align_in_ready", 36'(in_ready), 36'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release_in_ready", 36'(in_ready), 36'd1);
    repeat (15) @(negedge clk);
    chk("rst_no_out_valid", 36'(out_valid), 36'd0);

    issue(32'h40000000, 32'h3FF00000, 1'b1, 32'h3FF00000, 4'b1000,
          8'd101, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
